pcie_dn_fbuf_sched: RTL and testbench

//  Shares the downstream free-buffer descriptor queue (96-bit entries) among CH_NUM DMA channels.

---
 rtl/pcie_dn_fbuf_pkg.sv | 28 ++
 rtl/pcie_dn_fbuf_sched_arb.sv | 31 +++
 rtl/pcie_dn_fbuf_sched.sv | 133 +++++++++++++
 tb/tb_pcie_dn_fbuf_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_dn_fbuf_pkg.sv
// Shared constants, descriptor layout and FSM encoding for the
// downstream free-buffer scheduler.
package pcie_dn_fbuf_pkg;

  localparam int DESC_W  = 96;
  localparam int ADDR_LO = 0;
  localparam int ADDR_HI = 63;
  localparam int LEN_LO  = 64;
  localparam int LEN_HI  = 87;
  localparam int TAG_LO  = 88;
  localparam int TAG_HI  = 95;

  localparam logic [11:0] ALIGN_MASK = 12'hFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DELIV = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  function automatic logic desc_bad(input logic [DESC_W-1:0] d);
    return (d[LEN_HI:LEN_LO] == '0) ||
           ((d[11:0] & ALIGN_MASK) != 12'h000);
  endfunction

endpackage

// File: rtl/pcie_dn_fbuf_sched_arb.sv
// Combinational round-robin arbiter: first requester at or after
// the pointer, wrapping, as one-hot grant plus index.
module pcie_rr_arb #(
  parameter int CH_NUM = 4,
  parameter int CH_W   = 2
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_NUM-1:0] gnt,
  output logic [CH_W-1:0]   idx
);

  logic hit;
  int   j;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    j   = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      j = (int'(ptr) + i) % CH_NUM;
      if (!hit && req[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        idx    = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/pcie_dn_fbuf_sched.sv
// Free-buffer descriptor scheduler: one pop per grant, RR among channels.
// Optional drop of malformed descriptors: PCIE_DN_FBUF_SCHED_ERRCHK_EN.
module pcie_dn_fbuf_sched
  import pcie_dn_fbuf_pkg::*;
#(
  parameter int CH_NUM  = 4,
  parameter int CH_W    = 2,
  parameter int RD_LAT  = 3,
  parameter int HOLDOFF = 2
) (
  input  logic              PCIE_CLK,
  input  logic              PCIE_RST,
  input  logic              SCHED_EN,
  input  logic [CH_NUM-1:0] CH_REQ,
  output logic [CH_NUM-1:0] CH_ACK,
  output logic              DESC_VLD,
  output logic [CH_W-1:0]   DESC_CH,
  output logic [95:0]       DESC_DATA,
  input  logic              FBUF_RD_RDY,
  output logic              FBUF_RD_REQ,
  input  logic [95:0]       FBUF_RD_DATA,
  output logic              BUSY,
  output logic [15:0]       ERR_CNT
);

  localparam int CNT_W = $clog2(RD_LAT + HOLDOFF + 1);
  localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'(RD_LAT - 1);
  // the IDLE cycle counts toward the holdoff window
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLDOFF - 2);

  state_t state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CH_W-1:0]   ptr, ch, arb_idx;
  logic [CH_NUM-1:0] ch_oh, arb_gnt;
  logic              start, deliver, bad;

  pcie_rr_arb #(.CH_NUM(CH_NUM), .CH_W(CH_W)) u_arb (
    .req (CH_REQ),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

`ifdef PCIE_DN_FBUF_SCHED_ERRCHK_EN
  assign bad = desc_bad(FBUF_RD_DATA);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    deliver = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (SCHED_EN && FBUF_RD_RDY && |CH_REQ) begin
          start   = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_n   = LAT_LD;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (bad) begin
          cnt_n   = HOLD_LD;
          state_n = S_HOLD;
        end else begin
          deliver = 1'b1;
          state_n = S_DELIV;
        end
      end
      S_DELIV: begin
        cnt_n   = HOLD_LD;
        state_n = S_HOLD;
      end
      S_HOLD: begin
        if (cnt != '0) cnt_n = cnt - CNT_W'(1);
        else state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
    if (PCIE_RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ptr         <= '0;
      ch          <= '0;
      ch_oh       <= '0;
      CH_ACK      <= '0;
      DESC_VLD    <= 1'b0;
      DESC_CH     <= '0;
      DESC_DATA   <= '0;
      FBUF_RD_REQ <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      FBUF_RD_REQ <= start;
      BUSY        <= (state_n != S_IDLE);
      DESC_VLD    <= deliver;
      CH_ACK      <= deliver ? ch_oh : '0;
      if (start) begin
        ch    <= arb_idx;
        ch_oh <= arb_gnt;
      end
      if (deliver) begin
        DESC_CH   <= ch;
        DESC_DATA <= FBUF_RD_DATA;
      end
      if (state == S_DELIV)
        ptr <= (ch == CH_W'(CH_NUM - 1)) ? '0 : ch + CH_W'(1);
    end
  end

`ifdef PCIE_DN_FBUF_SCHED_ERRCHK_EN
  always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
    if (PCIE_RST)
      ERR_CNT <= '0;
    else if (state == S_WAIT && state_n == S_HOLD && ERR_CNT != 16'hFFFF)
      ERR_CNT <= ERR_CNT + 16'd1;
  end
`else
  assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_pcie_dn_fbuf_sched.sv
// Bench for pcie_dn_fbuf_sched: queue model with read latency,
// event log, and a round-robin/FIFO reference applied per scenario.
module tb_pcie_dn_fbuf_sched;

  localparam int CH_NUM  = 4;
  localparam int CH_W    = 2;
  localparam int RD_LAT  = 3;
  localparam int HOLDOFF = 2;
  localparam int PERIOD  = RD_LAT + 2 + HOLDOFF;

  logic              PCIE_CLK = 1'b0;
  logic              PCIE_RST = 1'b0;
  logic              SCHED_EN = 1'b0;
  logic [CH_NUM-1:0] CH_REQ = '0;
  logic [CH_NUM-1:0] CH_ACK;
  logic              DESC_VLD;
  logic [CH_W-1:0]   DESC_CH;
  logic [95:0]       DESC_DATA;
  logic              FBUF_RD_RDY = 1'b0;
  logic              FBUF_RD_REQ;
  logic [95:0]       FBUF_RD_DATA;
  logic              BUSY;
  logic [15:0]       ERR_CNT;

  pcie_dn_fbuf_sched #(
    .CH_NUM(CH_NUM), .CH_W(CH_W), .RD_LAT(RD_LAT), .HOLDOFF(HOLDOFF)
  ) dut (
    .PCIE_CLK    (PCIE_CLK),
    .PCIE_RST    (PCIE_RST),
    .SCHED_EN    (SCHED_EN),
    .CH_REQ      (CH_REQ),
    .CH_ACK      (CH_ACK),
    .DESC_VLD    (DESC_VLD),
    .DESC_CH     (DESC_CH),
    .DESC_DATA   (DESC_DATA),
    .FBUF_RD_RDY (FBUF_RD_RDY),
    .FBUF_RD_REQ (FBUF_RD_REQ),
    .FBUF_RD_DATA(FBUF_RD_DATA),
    .BUSY        (BUSY),
    .ERR_CNT     (ERR_CNT)
  );

  always #5 PCIE_CLK = ~PCIE_CLK;

  typedef struct {
    int          cyc;
    logic [1:0]  ch;
    logic [3:0]  ack;
    logic [95:0] data;
    logic        busy;
  } del_t;

  logic [95:0] fq[$];
  logic [95:0] stim[$];
  logic [95:0] pipe[RD_LAT];
  int          pop_q[$];
  del_t        del_q[$];
  int cyc = 0, n_under = 0, n_stray = 0, n_busy = 0;
  int n_vec = 0, n_err = 0;
  int mptr = 0, ecnt_m = 0;

  assign FBUF_RD_DATA = pipe[RD_LAT-1];

  always @(posedge PCIE_CLK) cyc <= cyc + 1;

  // queue: registered (one-cycle stale) ready, fixed read latency
  always @(posedge PCIE_CLK) begin : qmodel
    logic [95:0] nxt;
    int sz;
    nxt = {$urandom, $urandom, $urandom};
    sz  = fq.size();
    if (PCIE_RST) begin
      fq.delete();
      sz = 0;
    end else if (FBUF_RD_REQ) begin
      if (fq.size() == 0) n_under++;
      else nxt = fq.pop_front();
    end
    FBUF_RD_RDY <= (sz != 0);
    pipe[0] <= nxt;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  always @(negedge PCIE_CLK) begin
    if (!PCIE_RST) begin
      if (FBUF_RD_REQ) pop_q.push_back(cyc);
      if (DESC_VLD)
        del_q.push_back('{cyc, DESC_CH, CH_ACK, DESC_DATA, BUSY});
      if (!DESC_VLD && CH_ACK != '0) n_stray++;
      if (BUSY) n_busy++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge PCIE_CLK);
    #1;
  endtask

  function automatic logic is_bad(input logic [95:0] d);
`ifdef PCIE_DN_FBUF_SCHED_ERRCHK_EN
    return (d[87:64] == 24'd0) || (d[11:0] != 12'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int rr_pick(input logic [3:0] mask, input int p);
    for (int i = 0; i < CH_NUM; i++)
      if (mask[(p + i) % CH_NUM]) return (p + i) % CH_NUM;
    return -1;
  endfunction

  function automatic logic [95:0] mk_desc(input logic [63:0] a,
                                          input logic [23:0] l,
                                          input logic [7:0] t);
    return {t, l, a};
  endfunction

  task automatic chk_rst_outputs(input string nm);
    chk({nm, "_vld"}, DESC_VLD, 0);
    chk({nm, "_ack"}, CH_ACK, 0);
    chk({nm, "_rdreq"}, FBUF_RD_REQ, 0);
    chk({nm, "_busy"}, BUSY, 0);
    chk({nm, "_ch"}, DESC_CH, 0);
    chk({nm, "_data"}, DESC_DATA, 0);
    chk({nm, "_err"}, ERR_CNT, 0);
  endtask

  task automatic do_reset();
    PCIE_RST = 1'b1;
    #1;
    chk_rst_outputs("reset");
    step(2);
    PCIE_RST = 1'b0;
    mptr   = 0;
    ecnt_m = 0;
    step(2);
  endtask

  // pushes stim, holds mask until drained, then checks log vs model
  task automatic run_case(input string nm, input logic [3:0] mask);
    int n, ngood, d, c, tmo;
    logic prev_bad;
    pop_q.delete();
    del_q.delete();
    n = stim.size();
    ngood = 0;
    foreach (stim[k]) begin
      fq.push_back(stim[k]);
      if (!is_bad(stim[k])) ngood++;
    end
    CH_REQ = mask;
    tmo = 12 * n + 20;
    while (tmo > 0 && (pop_q.size() < n || del_q.size() < ngood)) begin
      step(1);
      tmo--;
    end
    step(15);
    CH_REQ = '0;
    chk({nm, "_pops"}, pop_q.size(), n);
    chk({nm, "_dels"}, del_q.size(), ngood);
    d = 0;
    prev_bad = 1'b0;
    for (int k = 0; k < n && k < pop_q.size(); k++) begin
      if (k > 0 && !prev_bad)
        chk({nm, "_gap"}, pop_q[k] - pop_q[k-1], PERIOD);
      prev_bad = is_bad(stim[k]);
      if (prev_bad) begin
        if (ecnt_m != 16'hFFFF) ecnt_m++;
      end else begin
        c = rr_pick(mask, mptr);
        if (d < del_q.size()) begin
          chk({nm, "_ch"}, del_q[d].ch, c);
          chk({nm, "_ack"}, del_q[d].ack, 4'b0001 << c);
          chk({nm, "_data"}, del_q[d].data, stim[k]);
          chk({nm, "_lat"}, del_q[d].cyc - pop_q[k], RD_LAT + 1);
          chk({nm, "_busy"}, del_q[d].busy, 1);
        end
        d++;
        mptr = (c + 1) % CH_NUM;
      end
    end
    chk({nm, "_errcnt"}, ERR_CNT, ecnt_m);
    stim.delete();
  endtask

  initial begin
    int tmo, c0;
    logic [63:0] a;
    #2;
    do_reset();
    SCHED_EN = 1'b1;

    // single channel, single descriptor
    stim.push_back(mk_desc(64'h1000, 24'h200, 8'h05));
    run_case("one", 4'b0001);

    // eight descriptors, all channels
    do_reset();
    for (int k = 0; k < 8; k++)
      stim.push_back(mk_desc({32'h0, 20'(k + 1), 12'h0}, 24'(k + 64), 8'(k)));
    run_case("all4", 4'b1111);

    // empty queue: no pop, stays idle
    pop_q.delete();
    n_busy = 0;
    CH_REQ = 4'b0110;
    step(50);
    CH_REQ = '0;
    chk("empty_pops", pop_q.size(), 0);
    chk("empty_busy", n_busy, 0);
    chk("empty_busy_now", BUSY, 0);

    // enable drops one cycle after the pop
    pop_q.delete();
    del_q.delete();
    stim.push_back(mk_desc(64'h5000, 24'h40, 8'hA1));
    stim.push_back(mk_desc(64'h6000, 24'h80, 8'hA2));
    foreach (stim[k]) fq.push_back(stim[k]);
    CH_REQ = 4'b0011;
    tmo = 50;
    while (tmo > 0 && pop_q.size() == 0) begin step(1); tmo--; end
    SCHED_EN = 1'b0;
    step(30);
    c0 = rr_pick(4'b0011, mptr);
    chk("en_off_pops", pop_q.size(), 1);
    chk("en_off_dels", del_q.size(), 1);
    if (del_q.size() > 0) begin
      chk("en_off_ch", del_q[0].ch, c0);
      chk("en_off_data", del_q[0].data, stim[0]);
    end
    mptr = (c0 + 1) % CH_NUM;
    SCHED_EN = 1'b1;
    tmo = 50;
    while (tmo > 0 && del_q.size() < 2) begin step(1); tmo--; end
    CH_REQ = '0;
    chk("en_on_dels", del_q.size(), 2);
    c0 = rr_pick(4'b0011, mptr);
    if (del_q.size() > 1) begin
      chk("en_on_ch", del_q[1].ch, c0);
      chk("en_on_data", del_q[1].data, stim[1]);
    end
    mptr = (c0 + 1) % CH_NUM;
    stim.delete();
    step(10);

    // reset during the read-latency wait
    pop_q.delete();
    del_q.delete();
    fq.push_back(mk_desc(64'h7000, 24'h10, 8'h33));
    CH_REQ = 4'b0001;
    tmo = 50;
    while (tmo > 0 && pop_q.size() == 0) begin step(1); tmo--; end
    chk("rst_mid_popped", pop_q.size(), 1);
    PCIE_RST = 1'b1;
    #1;
    chk_rst_outputs("rst_mid");
    step(2);
    PCIE_RST = 1'b0;
    mptr = 0;
    ecnt_m = 0;
    del_q.delete();
    pop_q.delete();
    step(15);
    CH_REQ = '0;
    chk("rst_mid_dels", del_q.size(), 0);
    chk("rst_mid_pops", pop_q.size(), 0);
    stim.push_back(mk_desc(64'h8000, 24'h20, 8'h44));
    run_case("rst_ptr", 4'b1111);

    // zero-length descriptor followed by a good one
    stim.push_back(mk_desc(64'h9000, 24'h0, 8'h55));
    stim.push_back(mk_desc(64'hA000, 24'h100, 8'h66));
    run_case("lenzero", 4'b0100);

    // randomized masks, depths and descriptor contents
    for (int it = 0; it < 8; it++) begin
      int n;
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        a = {$urandom, $urandom};
        a[11:0] = 12'h0;
        stim.push_back(mk_desc(a, 24'($urandom_range(1, 24'hFFFFFF)),
                               8'($urandom)));
      end
      run_case($sformatf("rand%0d", it), m);
    end

    chk("underflow", n_under, 0);
    chk("stray_ack", n_stray, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
